// File: rtl/speed_keys.sv
`default_nettype none
// =============================================================================
// speed_keys : synchronises and debounces the two speed pushbuttons and turns
//              presses into one-cycle faster/slower request pulses.
//              Optional auto-repeat: define SPEED_KEYS_AUTO_REPEAT_EN.
// Revision   : 1.0
// =============================================================================

module speed_keys #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_faster_n,
    input  logic key_slower_n,
    output logic faster,
    output logic slower,
    output logic held
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the faster key, bit 1 the slower key; 1 = debounced pressed.
    logic [1:0] w_pressed;

    generate
        for (genvar k = 0; k < 2; k++) begin : g_key
            logic          w_raw_n;
            logic          sync1_q;
            logic          sync2_q;
            logic          stable_q;
            logic          stable_d;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            assign w_raw_n = (k == 0) ? key_faster_n : key_slower_n;

            always_comb begin
                stable_d = stable_q;
                cnt_d    = '0;
                if (sync2_q != stable_q) begin
                    if (cnt_q == DB_LAST) begin
                        stable_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_q  <= 1'b1;
                    sync2_q  <= 1'b1;
                    stable_q <= 1'b1;
                    cnt_q    <= '0;
                end else begin
                    sync1_q  <= w_raw_n;
                    sync2_q  <= sync1_q;
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign w_pressed[k] = ~stable_q;
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD_F  = 2'd1,
        HELD_S  = 2'd2,
        BLOCKED = 2'd3
    } state_t;

    state_t state_q;
    logic   faster_q;
    logic   slower_q;
    logic   held_q;

    logic w_pf;
    logic w_ps;
    logic w_own;
    logic w_other;

    assign w_pf    = w_pressed[0];
    assign w_ps    = w_pressed[1];
    assign w_own   = (state_q == HELD_F) ? w_pf : w_ps;
    assign w_other = (state_q == HELD_F) ? w_ps : w_pf;

`ifdef SPEED_KEYS_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] rep_cnt_q;
    logic          rep_first_q;
    logic          w_rep_due;

    // First repeat waits the long delay, later ones the shorter period.
    assign w_rep_due = (rep_cnt_q == (rep_first_q ? RD_LAST : RP_LAST));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            faster_q    <= 1'b0;
            slower_q    <= 1'b0;
            held_q      <= 1'b0;
`ifdef SPEED_KEYS_AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            faster_q <= 1'b0;
            slower_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_pf && w_ps) begin
                        state_q <= BLOCKED;
                        held_q  <= 1'b1;
                    end else if (w_pf || w_ps) begin
                        state_q     <= w_pf ? HELD_F : HELD_S;
                        faster_q    <= w_pf;
                        slower_q    <= w_ps;
                        held_q      <= 1'b1;
`ifdef SPEED_KEYS_AUTO_REPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b1;
`endif
                    end
                end
                HELD_F, HELD_S: begin
                    if (!w_own) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end else if (w_other) begin
                        state_q <= BLOCKED;
`ifdef SPEED_KEYS_AUTO_REPEAT_EN
                    end else if (w_rep_due) begin
                        faster_q    <= (state_q == HELD_F);
                        slower_q    <= (state_q == HELD_S);
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b0;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + 1'b1;
`endif
                    end
                end
                BLOCKED: begin
                    if (!w_pf && !w_ps) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign faster = faster_q;
    assign slower = slower_q;
    assign held   = held_q;

endmodule

`default_nettype wire

// File: tb/tb_speed_keys.sv
`default_nettype none
// =============================================================================
// tb_speed_keys : directed bench for speed_keys with a cycle-level reference
//                 model and hand-computed pulse timing checks.
// Revision      : 1.0
// =============================================================================

module tb_speed_keys;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    localparam int NONE  = 0;
    localparam int OWN_F = 1;
    localparam int OWN_S = 2;
    localparam int BLK   = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic key_f   = 1'b1;
    logic key_s   = 1'b1;
    logic faster;
    logic slower;
    logic held;

    speed_keys #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_faster_n(key_f),
        .key_slower_n(key_s),
        .faster      (faster),
        .slower      (slower),
        .held        (held)
    );

    initial forever #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;
    int fq[$];
    int sq[$];
    int held_hi     = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit settle(input logic [D+1:0] h, input bit st);
        logic [D-1:0] w;
        w = h[D+1:2];
        if (st && (w == '0)) return 1'b0;
        if (!st && (&w))     return 1'b1;
        return st;
    endfunction

    function automatic bit repeat_due(input int age);
`ifdef SPEED_KEYS_AUTO_REPEAT_EN
        return (age >= RD) && (((age - RD) % RP) == 0);
`else
        return (age < 0);
`endif
    endfunction

    // Reference model: raw-sample history windows and pulse ages.
    logic [D+1:0] hf = '1;
    logic [D+1:0] hs = '1;
    bit st_f = 1'b1, st_s = 1'b1;
    bit m_f = 1'b0, m_s = 1'b0, m_h = 1'b0;
    bit m_pf, m_ps, m_own, m_other;
    int owner = NONE;
    int t0    = 0;
    int mcyc  = 0;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            hf = '1; hs = '1; st_f = 1'b1; st_s = 1'b1;
            owner = NONE; m_f = 1'b0; m_s = 1'b0; m_h = 1'b0;
        end else begin
            mcyc++;
            m_pf = !st_f;
            m_ps = !st_s;
            m_f  = 1'b0;
            m_s  = 1'b0;
            case (owner)
                NONE: begin
                    if (m_pf && m_ps) owner = BLK;
                    else if (m_pf) begin owner = OWN_F; t0 = mcyc; m_f = 1'b1; end
                    else if (m_ps) begin owner = OWN_S; t0 = mcyc; m_s = 1'b1; end
                end
                OWN_F, OWN_S: begin
                    m_own   = (owner == OWN_F) ? m_pf : m_ps;
                    m_other = (owner == OWN_F) ? m_ps : m_pf;
                    if (!m_own) owner = NONE;
                    else if (m_other) owner = BLK;
                    else if (repeat_due(mcyc - t0)) begin
                        if (owner == OWN_F) m_f = 1'b1;
                        else m_s = 1'b1;
                    end
                end
                default: if (!m_pf && !m_ps) owner = NONE;
            endcase
            m_h  = (owner != NONE);
            hf   = {hf[D:0], key_f};
            hs   = {hs[D:0], key_s};
            st_f = settle(hf, st_f);
            st_s = settle(hs, st_s);
        end
    end

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    initial forever begin
        @(negedge clk);
        check("model_faster", faster, m_f);
        check("model_slower", slower, m_s);
        check("model_held",   held,   m_h);
        check("excl_pulses",  faster & slower, 0);
        if (faster) fq.push_back(edge_cnt);
        if (slower) sq.push_back(edge_cnt);
        if (held)   held_hi++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int e;
    int exp_off[$];

    initial begin
`ifdef SPEED_KEYS_AUTO_REPEAT_EN
        exp_off = '{0, 20, 28, 36, 44, 52};
`else
        exp_off = '{0};
`endif
        #1 reset_n = 1'b0;
        cyc(3);
        check("rst_faster", faster, 0);
        check("rst_slower", slower, 0);
        check("rst_held",   held,   0);
        reset_n = 1'b1;
        fq.delete(); sq.delete(); held_hi = 0;
        cyc(50);
        check("idle_pulses", fq.size() + sq.size(), 0);

        // Single press: pulse in the cycle after edge N+6.
        e = edge_cnt;
        key_f = 1'b0;
        cyc(10);
        key_f = 1'b1;
        cyc(6);
        check("single_held_on", held, 1);
        cyc(1);
        check("single_held_off", held, 0);
        cyc(5);
        check("single_count", fq.size(), 1);
        check("single_edge", (fq.size() > 0) ? fq[0] : -1, e + 7);
        check("single_slower", sq.size(), 0);

        // Glitch rejection.
        fq.delete(); sq.delete(); held_hi = 0;
        for (int i = 0; i < 5; i++) begin
            key_s = 1'b0; cyc(3);
            key_s = 1'b1; cyc(2);
        end
        cyc(10);
        check("glitch_slower", sq.size(), 0);
        check("glitch_held", held_hi, 0);

        // Long hold.
        fq.delete(); sq.delete();
        e = edge_cnt;
        key_f = 1'b0;
        cyc(60);
        key_f = 1'b1;
        cyc(15);
        check("repeat_count", fq.size(), exp_off.size());
        for (int i = 0; i < exp_off.size(); i++)
            check("repeat_edge", (fq.size() > i) ? fq[i] : -1, e + 7 + exp_off[i]);

        // Both keys.
        fq.delete(); sq.delete();
        e = edge_cnt;
        key_f = 1'b0;
        cyc(10);
        key_s = 1'b0;
        cyc(40);
        check("both_faster_count", fq.size(), 1);
        check("both_faster_edge", (fq.size() > 0) ? fq[0] : -1, e + 7);
        check("both_slower_count", sq.size(), 0);
        check("both_held", held, 1);
        key_s = 1'b1;
        cyc(20);
        check("both_relS_pulses", fq.size() + sq.size(), 1);
        key_f = 1'b1;
        cyc(10);
        check("both_released_held", held, 0);
        fq.delete(); sq.delete();
        e = edge_cnt;
        key_s = 1'b0;
        cyc(10);
        check("after_block_slower", sq.size(), 1);
        check("after_block_edge", (sq.size() > 0) ? sq[0] : -1, e + 7);
        check("after_block_faster", fq.size(), 0);

        // Reset while HELD_S with key kept pressed.
        #1 reset_n = 1'b0;
        #1;
        check("midrst_faster", faster, 0);
        check("midrst_slower", slower, 0);
        check("midrst_held",   held,   0);
        @(negedge clk);
        cyc(1);
        reset_n = 1'b1;
        e = edge_cnt;
        fq.delete(); sq.delete();
        cyc(10);
        check("midrst_count", sq.size(), 1);
        check("midrst_edge", (sq.size() > 0) ? sq[0] : -1, e + 7);
        key_s = 1'b1;
        cyc(12);
        check("final_held", held, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/speed_keys.md
# speed_keys

Converts the two raw, active-low board pushbuttons into the single-cycle `faster` / `slower` request pulses consumed by the delay-control register. Each key is synchronized and debounced. A small FSM then turns presses into pulses, optionally with auto-repeat while a key is held. It sits between the top-level key pins and the delay-control block, in the same clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key change (10 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, default 25000000: cycles from the initial press pulse to the first repeat pulse.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat pulses.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_faster_n`  in  1  raw pushbutton, 0 = pressed, asynchronous to `clk`.
- `key_slower_n`  in  1  raw pushbutton, 0 = pressed, asynchronous to `clk`.
- `faster`  out  1  one-cycle request pulse to decrement the delay.
- `slower`  out  1  one-cycle request pulse to increment the delay.
- `held`  out  1  high while the FSM is in `HELD_F`, `HELD_S` or `BLOCKED`.

## Operation
**Synchronizer**
- Two-flop synchronizer per key.
- Both flops reset to 1 (released).

**Debouncer** (per key)
- State: a `stable` bit, reset value 1, and a counter, reset value 0.
- While the synchronized value equals `stable`, the counter is held at 0.
- While they differ, the counter increments each cycle.
- When the counter reaches `DEBOUNCE_CYCLES-1` and the values still differ, `stable` takes the new value and the counter clears.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles leaves `stable` unchanged.
- The counter is sized as clog2 of the largest parameter; it never wraps.

**FSM** (states `IDLE`, `HELD_F`, `HELD_S`, `BLOCKED`; reset state `IDLE`)
- `IDLE`, only F debounced pressed: pulse `faster`, go to `HELD_F`, clear the repeat counter.
- `IDLE`, only S pressed: pulse `slower`, go to `HELD_S`.
- `IDLE`, both become pressed in the same cycle: no pulse, go to `BLOCKED`.
- `HELD_F` / `HELD_S`, own key released: go to `IDLE` with no pulse.
- `HELD_F` / `HELD_S`, other key pressed: go to `BLOCKED` with no pulse; the repeat counter stops.
- `BLOCKED`: exit to `IDLE` only when both keys are debounced released.
- Invariant: `faster` and `slower` are never high in the same cycle.
- Outputs are registered. Each pulse is exactly one cycle high.
- Reset mid-operation: all state is cleared immediately (asynchronously). A key still held when `reset_n` rises is treated as a new press: it pulses once, after the full synchronizer plus debounce latency.

## Timing
- All outputs reset to 0.
- Let raw key low first be sampled at edge N:
  - synchronized value low at N+1;
  - `stable` falls at N+1+`DEBOUNCE_CYCLES`;
  - pulse high for the cycle after edge N+2+`DEBOUNCE_CYCLES`.
- `held` rises together with the initial pulse. It falls one cycle after `stable` returns high (or after both keys are released, from `BLOCKED`).
- Release is debounced with the same latency as press.
- Auto-repeat, counted from the initial pulse cycle:
  - first repeat pulse `REPEAT_DELAY` cycles later;
  - then one pulse every `REPEAT_PERIOD` cycles while the key stays held and the state is unchanged.

## Configuration
- Macro `SPEED_KEYS_AUTO_REPEAT_EN`.
- Defined: the repeat counter and the repeat pulses described above are compiled in.
- Undefined:
  - the repeat counter and the `REPEAT_*` logic are removed;
  - exactly one pulse is produced per debounced press;
  - the parameters remain declared but unused;
  - `held` behaviour is unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- Reset check: hold `reset_n`=0 with both keys high → `faster`=`slower`=`held`=0. Release reset, keys idle for 50 cycles → no pulses.
- Single press: `key_faster_n` low at edge N, held 10 cycles, then released → one `faster` pulse in the cycle after edge N+6; `slower` stays 0; `held` falls 6 cycles after release.
- Glitch rejection: `key_slower_n` low for 3 cycles, repeated 5 times with 2-cycle high gaps → no `slower` pulse, `held` stays 0.
- Auto-repeat (macro defined): hold `key_faster_n` low for 60 cycles → pulses at offsets 0, 20, 28, 36, 44, 52 from the initial pulse. With the macro undefined → a single pulse only.
- Both keys: press F, then press S 10 cycles later, hold both 40 cycles → one `faster` pulse and no further pulses. Release S only → still no pulses. Release F, then press S → one `slower` pulse.
- Reset mid-hold: assert `reset_n`=0 while in `HELD_S`, keeping the key pressed → outputs 0 immediately. After reset is deasserted → one `slower` pulse 6 cycles later.
